// File: rtl/dsi_hs_lane_serializer.sv
// Multi-lane DSI high-speed serializer.
// Frames each burst as HS-zero, sync word, payload words, HS-trail.
// One serial bit per lane per clock; all lanes share one state machine,
// so they stay word-aligned. ser_out and ser_oe come straight from flops.
module dsi_hs_lane_serializer #(
  parameter int              LANES       = 4,
  parameter int              WIDTH       = 8,
  parameter int              ZERO_WORDS  = 8,
  parameter int              TRAIL_WORDS = 4,
  parameter logic [WIDTH-1:0] SYNC_WORD  = WIDTH'(8'hB8)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hs_req,
  input  logic [LANES*WIDTH-1:0] data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic [LANES-1:0]       ser_out,
  output logic [LANES-1:0]       ser_oe,
  output logic                   busy
);

  localparam int               BW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0]    BIT_LAST   = BW'(WIDTH - 1);
  localparam logic [7:0]       ZERO_LAST  = 8'(ZERO_WORDS - 1);
  localparam logic [7:0]       TRAIL_LAST = 8'(TRAIL_WORDS - 1);
  localparam logic [WIDTH-1:0] SYNC_REST  = SYNC_WORD >> 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ZERO,
    S_SYNC,
    S_DATA,
    S_TRAIL
  } state_t;

  state_t                 r_state;
  logic [BW-1:0]          r_bit_cnt;
  logic [7:0]             r_word_cnt;
  logic [LANES-1:0]       r_ser;
  logic [LANES-1:0]       r_oe;
  logic [LANES*WIDTH-1:0] r_shift;

  state_t                 w_state_nxt;
  logic [BW-1:0]          w_bit_nxt;
  logic [7:0]             w_word_nxt;
  logic [LANES-1:0]       w_ser_nxt;
  logic [LANES-1:0]       w_oe_nxt;
  logic [LANES*WIDTH-1:0] w_shift_nxt;
  logic                   w_last_bit;

  logic [LANES-1:0]       w_step_bit;
  logic [LANES*WIDTH-1:0] w_step_shift;
  logic [LANES-1:0]       w_load_bit;
  logic [LANES*WIDTH-1:0] w_load_shift;
  logic [LANES-1:0]       w_sync_bit;
  logic [LANES*WIDTH-1:0] w_sync_shift;

  // Per-lane candidate shift-register contents: advance, load payload, load sync
  always_comb begin
    w_step_bit   = '0;
    w_step_shift = '0;
    w_load_bit   = '0;
    w_load_shift = '0;
    w_sync_bit   = '0;
    w_sync_shift = '0;
    for (int k = 0; k < LANES; k++) begin
      w_step_bit[k]                 = r_shift[k*WIDTH];
      w_step_shift[k*WIDTH +: WIDTH] = {1'b0, r_shift[k*WIDTH+1 +: WIDTH-1]};
      w_load_bit[k]                 = data_in[k*WIDTH];
      w_load_shift[k*WIDTH +: WIDTH] = {1'b0, data_in[k*WIDTH+1 +: WIDTH-1]};
      w_sync_bit[k]                 = SYNC_WORD[0];
      w_sync_shift[k*WIDTH +: WIDTH] = SYNC_REST;
    end
  end

  // Next-state and next-output logic; outputs are registered with the state
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_word_nxt  = r_word_cnt;
    w_ser_nxt   = r_ser;
    w_oe_nxt    = r_oe;
    w_shift_nxt = r_shift;
    w_last_bit  = (r_bit_cnt == BIT_LAST);

    unique case (r_state)
      S_IDLE: begin
        w_ser_nxt  = '0;
        w_oe_nxt   = '0;
        w_bit_nxt  = '0;
        w_word_nxt = '0;
        if (hs_req) begin
          w_state_nxt = S_ZERO;
          w_oe_nxt    = '1;
        end
      end
      S_ZERO: begin
        w_ser_nxt = '0;
        if (w_last_bit) begin
          w_bit_nxt = '0;
          if (r_word_cnt == ZERO_LAST) begin
            w_word_nxt  = '0;
            w_state_nxt = S_SYNC;
            w_ser_nxt   = w_sync_bit;
            w_shift_nxt = w_sync_shift;
          end else begin
            w_word_nxt = r_word_cnt + 8'd1;
          end
        end else begin
          w_bit_nxt = r_bit_cnt + BW'(1);
        end
      end
      S_SYNC, S_DATA: begin
        if (w_last_bit) begin
          // Word boundary: the only place a burst may continue or end
          w_bit_nxt = '0;
          if (data_valid) begin
            w_state_nxt = S_DATA;
            w_ser_nxt   = w_load_bit;
            w_shift_nxt = w_load_shift;
          end else begin
            w_state_nxt = S_TRAIL;
            w_word_nxt  = '0;
            w_ser_nxt   = ~r_ser;
          end
        end else begin
          w_bit_nxt   = r_bit_cnt + BW'(1);
          w_ser_nxt   = w_step_bit;
          w_shift_nxt = w_step_shift;
        end
      end
      S_TRAIL: begin
        if (w_last_bit) begin
          w_bit_nxt = '0;
          if (r_word_cnt == TRAIL_LAST) begin
            w_word_nxt  = '0;
            w_state_nxt = S_IDLE;
            w_ser_nxt   = '0;
            w_oe_nxt    = '0;
          end else begin
            w_word_nxt = r_word_cnt + 8'd1;
          end
        end else begin
          w_bit_nxt = r_bit_cnt + BW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ser_nxt   = '0;
        w_oe_nxt    = '0;
      end
    endcase
  end

  // State, counters and pad outputs; reset abandons a burst without a trail
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_ser      <= '0;
      r_oe       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_word_cnt <= w_word_nxt;
      r_ser      <= w_ser_nxt;
      r_oe       <= w_oe_nxt;
    end
  end

  // Payload shift registers hold only data, so they carry no reset
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  assign data_ready = !rst && ((r_state == S_SYNC) || (r_state == S_DATA)) && w_last_bit;
  assign ser_out    = r_ser;
  assign ser_oe     = r_oe;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_dsi_hs_lane_serializer.sv
// Bench for dsi_hs_lane_serializer: three parameterisations, expected
// per-cycle pad streams built from the burst framing rules.
module tb_dsi_hs_lane_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        hs[3];
  logic        dv[3];
  logic [63:0] din[3];

  logic       rdy0, rdy1, rdy2, bz0, bz1, bz2;
  logic [3:0] so0, oe0;
  logic [0:0] so1, oe1;
  logic [1:0] so2, oe2;

  dsi_hs_lane_serializer #(.LANES(4), .WIDTH(8), .ZERO_WORDS(2), .TRAIL_WORDS(1),
                           .SYNC_WORD(8'hB8)) u_c0 (
    .clk(clk), .rst(rst), .hs_req(hs[0]), .data_in(din[0][31:0]), .data_valid(dv[0]),
    .data_ready(rdy0), .ser_out(so0), .ser_oe(oe0), .busy(bz0));

  dsi_hs_lane_serializer #(.LANES(1), .WIDTH(4), .ZERO_WORDS(3), .TRAIL_WORDS(2),
                           .SYNC_WORD(4'hD)) u_c1 (
    .clk(clk), .rst(rst), .hs_req(hs[1]), .data_in(din[1][3:0]), .data_valid(dv[1]),
    .data_ready(rdy1), .ser_out(so1), .ser_oe(oe1), .busy(bz1));

  dsi_hs_lane_serializer #(.LANES(2), .WIDTH(16), .ZERO_WORDS(2), .TRAIL_WORDS(1),
                           .SYNC_WORD(16'h3B8C)) u_c2 (
    .clk(clk), .rst(rst), .hs_req(hs[2]), .data_in(din[2][31:0]), .data_valid(dv[2]),
    .data_ready(rdy2), .ser_out(so2), .ser_oe(oe2), .busy(bz2));

  int          CL[3] = '{4, 1, 2};
  int          CW[3] = '{8, 4, 16};
  int          CZ[3] = '{2, 3, 2};
  int          CT[3] = '{1, 2, 1};
  logic [15:0] CS[3] = '{16'h00B8, 16'h000D, 16'h3B8C};

  logic [3:0] so[3], oe[3];
  logic       rd[3], bz[3];
  always_comb begin
    so[0] = so0;          oe[0] = oe0;          rd[0] = rdy0; bz[0] = bz0;
    so[1] = {3'b0, so1};  oe[1] = {3'b0, oe1};  rd[1] = rdy1; bz[1] = bz1;
    so[2] = {2'b0, so2};  oe[2] = {2'b0, oe2};  rd[2] = rdy2; bz[2] = bz2;
  end

  typedef struct packed {
    logic       oe;
    logic       rdy;
    logic [3:0] ser;
  } ent_t;

  ent_t        q[$];
  logic [63:0] words[$];
  int          cur;
  int          checks;
  int          errors;
  int          oe_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] lmask(input int c);
    return 4'((1 << CL[c]) - 1);
  endfunction

  // Expected pad stream of one burst carrying the words currently in 'words'
  task automatic push_burst(input int c);
    ent_t       e;
    logic [3:0] last;
    for (int i = 0; i < CZ[c] * CW[c]; i++) begin
      e.oe = 1'b1; e.rdy = 1'b0; e.ser = 4'b0;
      q.push_back(e);
    end
    for (int b = 0; b < CW[c]; b++) begin
      e.oe = 1'b1; e.rdy = (b == CW[c] - 1);
      e.ser = CS[c][b] ? lmask(c) : 4'b0;
      q.push_back(e);
    end
    for (int j = 0; j < words.size(); j++) begin
      for (int b = 0; b < CW[c]; b++) begin
        e.oe = 1'b1; e.rdy = (b == CW[c] - 1); e.ser = 4'b0;
        for (int k = 0; k < CL[c]; k++) e.ser[k] = words[j][k*CW[c] + b];
        q.push_back(e);
      end
    end
    last = q[$].ser;
    for (int i = 0; i < CT[c] * CW[c]; i++) begin
      e.oe = 1'b1; e.rdy = 1'b0; e.ser = ~last & lmask(c);
      q.push_back(e);
    end
  endtask

  function automatic logic [63:0] rand_word(input int c);
    logic [63:0] m;
    m = (64'd1 << (CL[c] * CW[c])) - 64'd1;
    return {$urandom, $urandom} & m;
  endfunction

  // Per-cycle compare of every instance against the expected stream
  always @(negedge clk) begin
    ent_t       e;
    logic [9:0] act;
    logic [9:0] exp;
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        chk($sformatf("ready_in_rst_c%0d", c), {63'b0, rd[c]}, 64'd0);
      end else begin
        act = {bz[c], rd[c], oe[c], so[c]};
        if (c == cur && oe[c] != 4'b0) oe_cnt++;
        if (c == cur && q.size() > 0) begin
          e   = q.pop_front();
          exp = {e.oe, e.rdy, (e.oe ? lmask(c) : 4'b0), e.ser};
        end else begin
          exp = 10'b0;
        end
        chk($sformatf("cycle_c%0d", c), {54'b0, act}, {54'b0, exp});
      end
    end
  end

  // One burst on instance c with the payload in 'words'; abort_at >= 0 resets mid-burst
  task automatic run_burst(input int c, input int abort_at);
    int   n, len, xf, base;
    logic x;
    n        = words.size();
    cur      = c;
    base     = oe_cnt;
    din[c]   = (n > 0) ? words[0] : 64'd0;
    dv[c]    = (n > 0);
    hs[c]    = 1'b1;
    @(posedge clk); #1;
    hs[c] = 1'b0;
    push_burst(c);
    len = q.size();
    xf  = 0;
    for (int cyc = 0; cyc < len + 3; cyc++) begin
      @(negedge clk);
      x = rd[c] && dv[c];
      @(posedge clk); #1;
      if (x) begin
        xf++;
        if (xf >= n) dv[c] = 1'b0;
        else din[c] = words[xf];
      end
      if (cyc == abort_at) begin
        rst = 1'b1;
        dv[c] = 1'b0;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_mid_burst", {61'b0, bz[c], |oe[c], |so[c]}, 64'd0);
        break;
      end
    end
    if (abort_at < 0) begin
      chk($sformatf("xfers_c%0d", c), 64'(xf), 64'(n));
      chk($sformatf("oe_len_c%0d", c), 64'(oe_cnt - base),
          64'((CZ[c] + 1 + n + CT[c]) * CW[c]));
      chk($sformatf("drained_c%0d", c), 64'(q.size()), 64'd0);
    end else begin
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] acc;
    int         base;
    checks = 0; errors = 0; oe_cnt = 0; cur = 0;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      hs[c] = 1'b0; dv[c] = 1'b0; din[c] = 64'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_state", {54'b0, bz0, rdy0, oe0, so0}, 64'd0);

    // Hand-computed pins of the model (pushed and inspected without time passing)
    words.delete();
    words.push_back(64'h8100FF5A);
    push_burst(0);
    chk("pin_len_single", 64'(q.size()), 64'd40);
    acc = 8'd0;
    for (int i = 0; i < 8; i++) acc[i] = q[16 + i].ser[0];
    chk("pin_sync_lane0", {56'b0, acc}, 64'hB8);
    for (int i = 0; i < 8; i++) acc[i] = q[24 + i].ser[0];
    chk("pin_data_lane0", {56'b0, acc}, 64'h5A);
    chk("pin_trail_first", {60'b0, q[32].ser}, 64'b0101);
    chk("pin_trail_last", {60'b0, q[39].ser}, 64'b0101);
    q.delete();
    words.delete();
    push_burst(0);
    chk("pin_len_empty", 64'(q.size()), 64'd32);
    chk("pin_trail_empty", {60'b0, q[24].ser}, 64'd0);
    q.delete();
    push_burst(1);
    chk("pin_len_c1", 64'(q.size()), 64'd24);
    acc = 8'd0;
    for (int i = 0; i < 4; i++) acc[i] = q[12 + i].ser[0];
    chk("pin_sync_c1", {56'b0, acc}, 64'hD);
    q.delete();

    // Single word
    words.delete();
    words.push_back(64'h8100FF5A);
    run_burst(0, -1);

    // Empty burst
    words.delete();
    run_burst(0, -1);

    // Back-to-back payload
    words.delete();
    for (int j = 0; j < 100; j++) words.push_back(rand_word(0));
    run_burst(0, -1);

    // Reset during DATA
    words.delete();
    for (int j = 0; j < 10; j++) words.push_back(rand_word(0));
    run_burst(0, 30);

    // Retrigger with hs_req held high across two empty bursts
    cur  = 0;
    base = oe_cnt;
    words.delete();
    dv[0] = 1'b0;
    hs[0] = 1'b1;
    @(posedge clk); #1;
    push_burst(0);
    q.push_back(6'b0);
    push_burst(0);
    repeat (34) @(posedge clk);
    #1;
    hs[0] = 1'b0;
    repeat (36) @(posedge clk);
    #1;
    chk("retrigger_drained", 64'(q.size()), 64'd0);
    chk("retrigger_oe_len", 64'(oe_cnt - base), 64'd64);

    // Parameter sweep
    words.delete();
    for (int j = 0; j < 3; j++) words.push_back(rand_word(1));
    run_burst(1, -1);
    words.delete();
    run_burst(1, -1);
    words.delete();
    for (int j = 0; j < 4; j++) words.push_back(rand_word(2));
    run_burst(2, -1);

    // Random bursts
    for (int r = 0; r < 6; r++) begin
      int c;
      c = $urandom_range(0, 2);
      words.delete();
      for (int j = 0; j < $urandom_range(0, 6); j++) words.push_back(rand_word(c));
      run_burst(c, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #400000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
